// File: rtl/snes_button_events_if.sv
// Button-event bus: raw SNES poll inputs and FSM-side event queue outputs.
// master drives polls/pops (reader + FSM side); slave is the event block.
interface snes_button_events_if #(
    parameter int BTN_WIDTH = 12,
    parameter int DEPTH     = 8
);
    logic [BTN_WIDTH-1:0]       button_data;
    logic                       data_latch;
    logic                       evt_pop;
    logic                       clr_ovf;
    logic                       evt_valid;
    logic [3:0]                 evt_code;
    logic [$clog2(DEPTH):0]     evt_count;
    logic [BTN_WIDTH-1:0]       btn_level;
    logic                       overflow;

    modport master (
        output button_data, data_latch, evt_pop, clr_ovf,
        input  evt_valid, evt_code, evt_count, btn_level, overflow
    );

    modport slave (
        input  button_data, data_latch, evt_pop, clr_ovf,
        output evt_valid, evt_code, evt_count, btn_level, overflow
    );
endinterface

// File: rtl/snes_button_events.sv
// Debounces SNES polls and queues press events (FWFT FIFO); latch->cap 3 clk, cap->evt_valid 3 clk.
// No backpressure to the reader: pushes into a full FIFO without a pop are dropped and flag overflow.
module snes_button_events #(
    parameter int BTN_WIDTH    = 12,
    parameter int DEPTH        = 8,
    parameter int STABLE_POLLS = 2
) (
    input logic                   clk,
    input logic                   reset,
    snes_button_events_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (STABLE_POLLS > 1) ? $clog2(STABLE_POLLS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_POLLS - 1);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);

    logic                 lat_s1, lat_s2, lat_d, cap, cap_d;
    logic [BTN_WIDTH-1:0] bd_s1, bd_s2, cap_word;
    logic [BTN_WIDTH-1:0] btn_level, level_nxt, rise, pending, clr_mask;
    logic [CW-1:0]        cnt     [BTN_WIDTH];
    logic [CW-1:0]        cnt_nxt [BTN_WIDTH];
    logic                 push;
    logic [3:0]           push_code;
    logic [3:0]           mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 overflow;
    logic                 empty, full, do_pop, do_push, drop;

    // Button word rides a 2-flop stage alongside the latch so both arrive together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_s1   <= 1'b0;
            lat_s2   <= 1'b0;
            lat_d    <= 1'b0;
            cap      <= 1'b0;
            cap_d    <= 1'b0;
            bd_s1    <= '0;
            bd_s2    <= '0;
            cap_word <= '0;
        end else begin
            lat_s1 <= bus.data_latch;
            lat_s2 <= lat_s1;
            lat_d  <= lat_s2;
            cap    <= lat_s2 & ~lat_d;
            cap_d  <= cap;
            bd_s1  <= bus.button_data;
            bd_s2  <= bd_s1;
            if (cap) cap_word <= bd_s2;
        end
    end

    always_comb begin
        level_nxt = btn_level;
        rise      = '0;
        for (int i = 0; i < BTN_WIDTH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (cap_d) begin
                if (cap_word[i] == btn_level[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt[i] == CNT_MAX) begin
                    cnt_nxt[i]   = '0;
                    level_nxt[i] = ~btn_level[i];
                    rise[i]      = ~btn_level[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Descending scan so the last hit is the lowest pending index.
    always_comb begin
        push      = 1'b0;
        push_code = 4'd0;
        clr_mask  = '0;
        for (int i = BTN_WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                push        = 1'b1;
                push_code   = 4'(i);
                clr_mask    = '0;
                clr_mask[i] = 1'b1;
            end
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == FULL);
    assign do_pop  = bus.evt_pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_level <= '0;
            pending   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            for (int i = 0; i < BTN_WIDTH; i++) cnt[i] <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 4'd0;
        end else begin
            btn_level <= level_nxt;
            cnt       <= cnt_nxt;
            pending   <= (pending & ~clr_mask) | rise;
            if (do_push) begin
                mem[wr_ptr] <= push_code;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as clr_ovf keeps the flag set.
            if (drop)             overflow <= 1'b1;
            else if (bus.clr_ovf) overflow <= 1'b0;
        end
    end

    assign bus.evt_valid = ~empty;
    assign bus.evt_code  = empty ? 4'd0 : mem[rd_ptr];
    assign bus.evt_count = count;
    assign bus.btn_level = btn_level;
    assign bus.overflow  = overflow;
endmodule

// File: doc/snes_button_events.md
Name: snes_button_events

Overview:
Converts the raw 12-bit SNES button word into a queue of debounced button-press events for the control FSM. It sits between the SNES serial reader, which runs in the divided 1.2 MHz domain, and the FSM, which runs in the system-clock domain. It resynchronises the poll strobe, debounces each button across successive polls and detects press (rising) edges. Each press becomes a 4-bit event code in a small first-word-fall-through FIFO. The FSM pops events one at a time and can also read the current debounced button levels.

Parameters:
BTN_WIDTH, 12, number of buttons in button_data; max 16
DEPTH, 8, FIFO entries; power of two, at least 2
STABLE_POLLS, 2, consecutive identical polls needed to change a debounced level; at least 1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
button_data  input  BTN_WIDTH  raw button word from the SNES reader; 1 = pressed; bit i = button i
data_latch  input  1  SNES latch pulse from the slow domain; marks the start of a new poll
evt_pop  input  1  FSM consumes the head event this cycle
clr_ovf  input  1  clears the overflow flag
evt_valid  output  1  FIFO is non-empty
evt_code  output  4  button index of the head event; 0 when empty
evt_count  output  log2(DEPTH)+1  number of queued events
btn_level  output  BTN_WIDTH  debounced button levels
overflow  output  1  sticky; set when an event was dropped

Behaviour:
- Reset (asynchronous, active-high) clears every register:
  - outputs: evt_valid=0, evt_code=0, evt_count=0, btn_level=0, overflow=0
  - internal: synchroniser, debounce counters, pending mask, FIFO pointers
- Reset asserted mid-operation discards all queued and pending events immediately. Normal operation resumes on the first clk edge after reset deasserts.
- Sync and capture:
  - data_latch passes through a 2-flop synchroniser plus an edge register.
  - A rising edge of the synchronised latch produces a one-cycle cap strobe.
  - button_data is stable at that point and is registered into cap_word on the cap cycle. It passes through a 2-flop stage in parallel with the latch so both share the same latency.
- Debounce, per button i, one cycle after cap:
  - cap_word[i]==btn_level[i]: cnt[i] resets to 0.
  - Otherwise cnt[i] increments. When it reaches STABLE_POLLS-1, btn_level[i] toggles and cnt[i] resets to 0.
  - With STABLE_POLLS=1 the level follows cap_word on the next cycle.
- Edge detect: a btn_level[i] transition 0->1 sets pending[i] in the same cycle the level updates. Releases (1->0) generate no event.
- Drain, every clk cycle:
  - If pending != 0, the lowest set index k is cleared from pending and pushed as code k.
  - One push per cycle at most, so simultaneous presses enqueue in ascending index order on consecutive cycles.
  - A new edge on a bit that is still pending merges with it and produces no duplicate.
- FIFO:
  - Circular buffer; read/write pointers wrap at DEPTH; evt_count tracks occupancy 0..DEPTH.
  - evt_code and evt_valid are combinational from the head entry (fall-through). The popped entry leaves on the clk edge where evt_pop=1 and evt_valid=1.
  - evt_pop while empty is ignored.
  - Push while full and no pop in the same cycle: the event is dropped (its pending bit is still cleared), overflow sets to 1, and the FIFO is unchanged.
  - Push and pop in the same cycle while full: both take effect, nothing is dropped, and evt_count stays DEPTH.
  - Push and pop in the same cycle while empty: the push is stored and the pop is ignored, giving evt_count=1.
- overflow is sticky and clears only when clr_ovf=1. If clr_ovf and a new drop happen in the same cycle, overflow stays 1 (set wins).
- Latency: a latch rising edge reaches the cap strobe after 3 clk. For a single press with STABLE_POLLS=1, evt_valid rises 3 clk after the cap strobe (cap_word register, debounce/edge, drain push).

Test Plan:
1. Reset mid-operation: load 3 events, assert reset for 1 cycle -> evt_count=0, evt_valid=0, overflow=0, btn_level=0; the next press is queued normally.
2. Single press, STABLE_POLLS=2: button_data=12'h010 held for 2 latch pulses -> btn_level[4]=1 after the 2nd poll; exactly one event with code 4; evt_count=1. Holding for 5 more polls adds no events.
3. Debounce glitch: button 0 pressed for 1 poll, then released -> btn_level stays 0 and no event is queued.
4. Simultaneous presses: button_data=12'h881 stable -> codes 0, 7, 11 are popped in that order on consecutive pushes; evt_count peaks at 3.
5. Overflow, DEPTH=8: generate 9 distinct press events with no pops -> evt_count=8, overflow=1, head code equals the first event. Pulse clr_ovf -> overflow=0.
6. Full push/pop: with the FIFO full, pop in the same cycle a new event is pushed -> evt_count stays 8, overflow stays 0, and the new code appears at the tail after 8 pops. A pop while empty leaves evt_count=0.
